// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, coin values and segment glyphs for the vending controller
package vend_pkg;
  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} vend_state_e;
  localparam int COIN1_VAL = 1;
  localparam int COIN2_VAL = 2;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO = 7'h40;
endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: 4-bit value to active-low a..g (bit0..6) glyph, blank above 9
module seg7_decoder
  import vend_pkg::*;
(
  input  logic [3:0] bin,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (bin)
      4'd0: seg = SEG_ZERO;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/vending_controller.sv
// vending_controller: key-edge events, coin credit, timed dispense and change strobe
// Optional VEND_SEG7_EN adds hex0, a registered active-low digit of the credit.
module vending_controller
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 4,
  parameter int PRICE = 3,
  parameter int MAX_CREDIT = 9,
  parameter int DISP_CYC = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bt_coin1,
  input  logic                bt_coin2,
  input  logic                bt_buy,
  input  logic                bt_cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic [CREDIT_W-1:0] change,
  output logic                change_vld,
  output logic                coin_reject,
  output logic                busy
`ifdef VEND_SEG7_EN
  ,
  output logic [6:0]          hex0
`endif
);
  localparam int CNT_W = DISP_CYC > 1 ? $clog2(DISP_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DISP_CYC - 1);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W + 1)'(MAX_CREDIT);
  vend_state_e state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, refund_q, refund_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] prev_q, keys, ev;
  logic rej_q, rej_d, arm_q;
  logic [CREDIT_W:0] coin_val, sum;
  assign keys = {bt_cancel, bt_buy, bt_coin2, bt_coin1};
  // arm_q masks the first post-reset cycle so a key held through reset is not a press
  assign ev = prev_q & ~keys & {4{arm_q}};
  assign coin_val = ev[1] ? (CREDIT_W + 1)'(COIN2_VAL) : (CREDIT_W + 1)'(COIN1_VAL);
  assign sum = {1'b0, credit_q} + coin_val;
  always_comb begin
    state_d = state_q;
    credit_d = credit_q;
    refund_d = refund_q;
    cnt_d = '0;
    rej_d = 1'b0;
    case (state_q)
      IDLE, CREDIT: begin
        if (ev[3]) begin
          state_d = CHANGE;
          refund_d = credit_q;
        end else if (ev[2]) begin
          state_d = credit_q >= PRICE_C ? DISPENSE : state_q;
        end else if (ev[1] || ev[0]) begin
          credit_d = sum <= MAX_C ? sum[CREDIT_W-1:0] : credit_q;
          state_d = sum <= MAX_C ? CREDIT : state_q;
          rej_d = sum > MAX_C;
        end
      end
      DISPENSE: begin
        cnt_d = cnt_q == CNT_LAST ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CNT_LAST ? CHANGE : DISPENSE;
        refund_d = cnt_q == CNT_LAST ? credit_q - PRICE_C : refund_q;
      end
      CHANGE: begin
        state_d = IDLE;
        credit_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      credit_q <= '0;
      refund_q <= '0;
      cnt_q <= '0;
      rej_q <= 1'b0;
      prev_q <= '1;
      arm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      refund_q <= refund_d;
      cnt_q <= cnt_d;
      rej_q <= rej_d;
      prev_q <= keys;
      arm_q <= 1'b1;
    end
  end
  assign credit = credit_q;
  assign dispense = state_q == DISPENSE;
  assign change_vld = state_q == CHANGE;
  assign change = change_vld ? refund_q : '0;
  assign coin_reject = rej_q;
  assign busy = dispense | change_vld;
`ifdef VEND_SEG7_EN
  logic [6:0] hex_q, hex_d;
  seg7_decoder u_seg (
    .bin(credit_q[3:0]),
    .seg(hex_d)
  );
  always_ff @(posedge clk) begin
    if (rst) hex_q <= SEG_ZERO;
    else hex_q <= hex_d;
  end
  assign hex0 = hex_q;
`endif
endmodule

// File: tb/tb_vending_controller.sv
// tb_vending_controller: directed checks of credit, dispense timing, change, reject and reset
module tb_vending_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] keys = 4'hF;
  logic [3:0] credit, change;
  logic dispense, change_vld, coin_reject, busy;
  int n_cmp = 0;
  int n_bad = 0;
`ifdef VEND_SEG7_EN
  logic [6:0] hex0;
`endif
  always #5 clk = ~clk;
  vending_controller #(
    .CREDIT_W(4),
    .PRICE(3),
    .MAX_CREDIT(9),
    .DISP_CYC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bt_coin1(keys[0]),
    .bt_coin2(keys[1]),
    .bt_buy(keys[2]),
    .bt_cancel(keys[3]),
    .credit(credit),
    .dispense(dispense),
    .change(change),
    .change_vld(change_vld),
    .coin_reject(coin_reject),
    .busy(busy)
`ifdef VEND_SEG7_EN
    ,
    .hex0(hex0)
`endif
  );
  localparam logic [3:0] K_C1 = 4'b0001, K_C2 = 4'b0010, K_BUY = 4'b0100, K_CAN = 4'b1000;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic press(input logic [3:0] m);
    keys = ~m;
    tick(1);
    keys = 4'hF;
    tick(1);
  endtask
  initial begin
    keys = ~K_C1;
    tick(3);
    rst = 1'b0;
    tick(10);
    chk("rst_credit", 8'(credit), 8'd0);
    chk("rst_dispense", 8'(dispense), 8'd0);
    chk("rst_change", 8'(change), 8'd0);
    chk("rst_change_vld", 8'(change_vld), 8'd0);
    chk("rst_reject", 8'(coin_reject), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
`ifdef VEND_SEG7_EN
    chk("rst_hex0", 8'(hex0), 8'h40);
`endif
    keys = 4'hF;
    tick(1);
    chk("held_key_credit", 8'(credit), 8'd0);
    press(K_C2);
    chk("coin2_a", 8'(credit), 8'd2);
    press(K_C2);
    chk("coin2_b", 8'(credit), 8'd4);
    keys = ~K_BUY;
    tick(1);
    keys = 4'hF;
    chk("buy_busy", 8'(busy), 8'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("disp_cyc%0d", i), 8'(dispense), 8'd1);
      chk($sformatf("disp_nochg%0d", i), 8'(change_vld), 8'd0);
      if (i < 3) tick(1);
    end
    tick(1);
    chk("disp_end", 8'(dispense), 8'd0);
    chk("chg_vld", 8'(change_vld), 8'd1);
    chk("chg_val", 8'(change), 8'd1);
    tick(1);
    chk("chg_one_cycle", 8'(change_vld), 8'd0);
    chk("chg_credit0", 8'(credit), 8'd0);
    chk("chg_idle", 8'(busy), 8'd0);
    for (int i = 1; i <= 4; i++) begin
      press(K_C2);
      chk($sformatf("fill_%0d", i), 8'(credit), 8'(2 * i));
    end
    keys = ~K_C2;
    tick(1);
    keys = 4'hF;
    chk("reject_strobe", 8'(coin_reject), 8'd1);
    chk("reject_credit", 8'(credit), 8'd8);
    tick(1);
    chk("reject_one_cycle", 8'(coin_reject), 8'd0);
    press(K_C1);
    chk("coin1_to_max", 8'(credit), 8'd9);
    chk("coin1_no_reject", 8'(coin_reject), 8'd0);
    keys = ~K_CAN;
    tick(1);
    keys = 4'hF;
    chk("cancel9_vld", 8'(change_vld), 8'd1);
    chk("cancel9_val", 8'(change), 8'd9);
    tick(1);
    chk("cancel9_credit", 8'(credit), 8'd0);
    press(K_C2);
    press(K_BUY);
    chk("short_buy_disp", 8'(dispense), 8'd0);
    chk("short_buy_busy", 8'(busy), 8'd0);
    chk("short_buy_credit", 8'(credit), 8'd2);
    keys = ~K_CAN;
    tick(1);
    keys = 4'hF;
    chk("cancel2_vld", 8'(change_vld), 8'd1);
    chk("cancel2_val", 8'(change), 8'd2);
    tick(1);
    chk("cancel2_credit", 8'(credit), 8'd0);
    press(K_C2);
    press(K_C1);
    chk("credit3", 8'(credit), 8'd3);
    keys = ~(K_BUY | K_C1);
    tick(1);
    keys = 4'hF;
    chk("prio_disp", 8'(dispense), 8'd1);
    chk("prio_coin_drop", 8'(credit), 8'd3);
    press(K_C1);
    chk("busy_coin_ignored", 8'(credit), 8'd3);
    chk("busy_no_reject", 8'(coin_reject), 8'd0);
    tick(1);
    chk("prio_disp_last", 8'(dispense), 8'd1);
    tick(1);
    chk("prio_chg_vld", 8'(change_vld), 8'd1);
    chk("prio_chg_val", 8'(change), 8'd0);
    tick(1);
    chk("prio_credit0", 8'(credit), 8'd0);
    press(K_C2);
    press(K_C1);
    keys = ~K_BUY;
    tick(1);
    keys = 4'hF;
    tick(1);
    chk("rst_mid_disp2", 8'(dispense), 8'd1);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_disp", 8'(dispense), 8'd0);
    chk("rst_mid_credit", 8'(credit), 8'd0);
    chk("rst_mid_vld", 8'(change_vld), 8'd0);
    rst = 1'b0;
    tick(1);
    chk("rst_mid_vld2", 8'(change_vld), 8'd0);
    chk("rst_mid_busy", 8'(busy), 8'd0);
    chk("rst_mid_credit2", 8'(credit), 8'd0);
`ifdef VEND_SEG7_EN
    press(K_C2);
    press(K_C2);
    keys = ~K_C1;
    tick(1);
    keys = 4'hF;
    chk("seg_credit5", 8'(credit), 8'd5);
    chk("seg_lag", 8'(hex0), 8'h19);
    tick(1);
    chk("seg_five", 8'(hex0), 8'h12);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
